// File: rtl/dispatcher_exp_unpacker.sv
// Unpacks staged packed-exponent lines from the dispatcher BRAM into one aligned
// exponent per group, writing into the left or right aligned-exponent buffer.
module dispatcher_exp_unpacker #(
  parameter int DATA_WIDTH    = 256,
  parameter int EXP_WIDTH     = 8,
  parameter int EXPS_PER_LINE = DATA_WIDTH / EXP_WIDTH,
  parameter int NUM_EXP       = 512
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_target,
  input  logic [4:0]            i_packed_lines_avail,
  output logic [3:0]            o_packed_rd_addr,
  output logic                  o_packed_rd_target,
  input  logic [DATA_WIDTH-1:0] i_packed_rd_data,
  output logic [8:0]            o_left_exp_wr_addr,
  output logic [EXP_WIDTH-1:0]  o_left_exp_wr_data,
  output logic                  o_left_exp_wr_en,
  output logic [8:0]            o_right_exp_wr_addr,
  output logic [EXP_WIDTH-1:0]  o_right_exp_wr_data,
  output logic                  o_right_exp_wr_en,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BYTE_W    = $clog2(EXPS_PER_LINE);
  localparam int NUM_LINES = NUM_EXP / EXPS_PER_LINE;

  localparam logic [3:0]        LAST_LINE = 4'(NUM_LINES - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(EXPS_PER_LINE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                state, state_nx;
  logic                  target_q;
  logic [3:0]            line_q;
  logic [BYTE_W-1:0]     byte_idx_q;
  logic [DATA_WIDTH-1:0] shadow_q;

  logic                 line_ready;
  logic                 last_byte;
  logic [8:0]           exp_idx;
  logic [EXP_WIDTH-1:0] exp_byte;

  assign line_ready = {1'b0, line_q} < i_packed_lines_avail;
  assign last_byte  = (byte_idx_q == LAST_BYTE);
  assign exp_idx    = 9'(line_q) * 9'(EXPS_PER_LINE) + 9'(byte_idx_q);
  assign exp_byte   = shadow_q[EXP_WIDTH*byte_idx_q +: EXP_WIDTH];

  assign o_packed_rd_target = target_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  // The shadow line is an ordinary register, so it is cleared with the rest of
  // the datapath; it decouples EMIT from later BRAM writes or address changes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      target_q   <= 1'b0;
      line_q     <= '0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          target_q <= i_target;
          line_q   <= '0;
        end
        S_LOAD: if (line_ready) begin
          shadow_q   <= i_packed_rd_data;
          byte_idx_q <= '0;
        end
        S_EMIT: begin
          byte_idx_q <= byte_idx_q + 1'b1;
          if (last_byte && line_q != LAST_LINE) line_q <= line_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and the next state get a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx            = state;
    o_packed_rd_addr    = '0;
    o_left_exp_wr_addr  = '0;
    o_left_exp_wr_data  = '0;
    o_left_exp_wr_en    = 1'b0;
    o_right_exp_wr_addr = '0;
    o_right_exp_wr_data = '0;
    o_right_exp_wr_en   = 1'b0;
    o_busy              = 1'b0;
    o_done              = 1'b0;
    case (state)
      S_IDLE: if (i_start) state_nx = S_LOAD;
      S_LOAD: begin
        o_busy           = 1'b1;
        o_packed_rd_addr = line_q;
        if (line_ready) state_nx = S_EMIT;
      end
      S_EMIT: begin
        o_busy = 1'b1;
        if (target_q) begin
          o_right_exp_wr_en   = 1'b1;
          o_right_exp_wr_addr = exp_idx;
          o_right_exp_wr_data = exp_byte;
        end else begin
          o_left_exp_wr_en    = 1'b1;
          o_left_exp_wr_addr  = exp_idx;
          o_left_exp_wr_data  = exp_byte;
        end
        if (last_byte) state_nx = (line_q == LAST_LINE) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        o_done   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dispatcher_exp_unpacker.sv
// Directed bench for dispatcher_exp_unpacker: a full-size instance and a
// NUM_EXP=128 instance share one packed-line model and a per-instance scoreboard.
module tb_dispatcher_exp_unpacker;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic         i_reset = 1'b1;
  logic         i_start = 1'b0, i_target = 1'b0;
  logic         s_start = 1'b0, s_target = 1'b0;
  logic [4:0]   i_packed_lines_avail = 5'd0;

  logic [3:0]   o_packed_rd_addr, s_rd_addr;
  logic         o_packed_rd_target, s_rd_target;
  logic [255:0] i_packed_rd_data, s_rd_data;
  logic [8:0]   o_left_exp_wr_addr, o_right_exp_wr_addr, s_left_addr, s_right_addr;
  logic [7:0]   o_left_exp_wr_data, o_right_exp_wr_data, s_left_data, s_right_data;
  logic         o_left_exp_wr_en, o_right_exp_wr_en, s_left_en, s_right_en;
  logic         o_busy, o_done, s_busy, s_done;

  logic [255:0] packed_mem [2][16];
  assign i_packed_rd_data = packed_mem[o_packed_rd_target][o_packed_rd_addr];
  assign s_rd_data        = packed_mem[s_rd_target][s_rd_addr];

  dispatcher_exp_unpacker dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_target(i_target),
    .i_packed_lines_avail(i_packed_lines_avail),
    .o_packed_rd_addr(o_packed_rd_addr), .o_packed_rd_target(o_packed_rd_target),
    .i_packed_rd_data(i_packed_rd_data),
    .o_left_exp_wr_addr(o_left_exp_wr_addr), .o_left_exp_wr_data(o_left_exp_wr_data),
    .o_left_exp_wr_en(o_left_exp_wr_en),
    .o_right_exp_wr_addr(o_right_exp_wr_addr), .o_right_exp_wr_data(o_right_exp_wr_data),
    .o_right_exp_wr_en(o_right_exp_wr_en),
    .o_busy(o_busy), .o_done(o_done)
  );

  dispatcher_exp_unpacker #(.NUM_EXP(128)) dut_small (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(s_start), .i_target(s_target),
    .i_packed_lines_avail(i_packed_lines_avail),
    .o_packed_rd_addr(s_rd_addr), .o_packed_rd_target(s_rd_target),
    .i_packed_rd_data(s_rd_data),
    .o_left_exp_wr_addr(s_left_addr), .o_left_exp_wr_data(s_left_data),
    .o_left_exp_wr_en(s_left_en),
    .o_right_exp_wr_addr(s_right_addr), .o_right_exp_wr_data(s_right_data),
    .o_right_exp_wr_en(s_right_en),
    .o_busy(s_busy), .o_done(s_done)
  );

  typedef struct packed {
    logic       side;
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t sb0[$];
  wr_t sb1[$];

  int checks = 0, failures = 0;
  int cyc = 0, done_cyc = -1, s_done_cyc = -1;
  int wr_cnt[2], right_cnt[2], first_wr[2], last_wr[2];
  bit ramp = 1'b0;
  int corrupt_cyc = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic mon(input int inst, input logic len, input logic [8:0] la, input logic [7:0] ld,
                     input logic ren, input logic [8:0] ra, input logic [7:0] rd);
    wr_t got, exp;
    int  n;
    if (!(len || ren)) return;
    check($sformatf("one_side_%0d", inst), 64'(len & ren), 64'd0);
    check($sformatf("idle_side_zero_%0d", inst), ren ? 64'({len, la, ld}) : 64'({ren, ra, rd}), 64'd0);
    got = ren ? {1'b1, ra, rd} : {1'b0, la, ld};
    n = (inst == 0) ? sb0.size() : sb1.size();
    check($sformatf("sb_nonempty_%0d", inst), 64'(n != 0), 64'd1);
    if (n != 0) begin
      exp = (inst == 0) ? sb0.pop_front() : sb1.pop_front();
      check($sformatf("write_%0d", inst), 64'(got), 64'(exp));
    end
    if (wr_cnt[inst] == 0) first_wr[inst] = cyc;
    last_wr[inst] = cyc;
    wr_cnt[inst]++;
    if (ren) right_cnt[inst]++;
  endtask

  task automatic tick();
    int a;
    @(posedge i_clk);
    #1;
    cyc++;
    if (ramp) begin
      a = (cyc <= 10) ? 0 : (cyc - 11) / 33 + 1;
      if (a > 16) a = 16;
      i_packed_lines_avail = 5'(a);
    end
    if (cyc == corrupt_cyc) packed_mem[0][3] = ~packed_mem[0][3];
    mon(0, o_left_exp_wr_en, o_left_exp_wr_addr, o_left_exp_wr_data,
        o_right_exp_wr_en, o_right_exp_wr_addr, o_right_exp_wr_data);
    mon(1, s_left_en, s_left_addr, s_left_data, s_right_en, s_right_addr, s_right_data);
    if (o_done) done_cyc = cyc;
    if (s_done) s_done_cyc = cyc;
  endtask

  // Pushes the expected write stream, then drives start so that the start
  // cycle is cycle 0; returns in cycle 1.
  task automatic begin_job(input int inst, input logic tgt, input int nlines);
    wr_t e;
    for (int n = 0; n < nlines; n++)
      for (int b = 0; b < 32; b++) begin
        e.side = tgt;
        e.addr = 9'(n * 32 + b);
        e.data = packed_mem[tgt][n][8*b +: 8];
        if (inst == 0) sb0.push_back(e); else sb1.push_back(e);
      end
    wr_cnt[inst] = 0; right_cnt[inst] = 0; first_wr[inst] = -1; last_wr[inst] = -1;
    done_cyc = -1; s_done_cyc = -1;
    tick();
    cyc = 0;
    if (inst == 0) begin i_start = 1'b1; i_target = tgt; end
    else           begin s_start = 1'b1; s_target = tgt; end
    tick();
    i_start = 1'b0; s_start = 1'b0;
  endtask

  task automatic wait_done_main(input logic tgt, input int budget);
    int n = 0;
    while (done_cyc < 0 && n < budget) begin
      check("busy", 64'(o_busy), 64'd1);
      check("rd_target", 64'(o_packed_rd_target), 64'(tgt));
      tick();
      n++;
    end
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("busy_at_done", 64'(o_busy), 64'd0);
    tick();
    check("done_pulse_len", 64'(o_done), 64'd0);
    check("sb_drained", 64'(sb0.size()), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_packed_rd_addr, o_packed_rd_target, o_left_exp_wr_addr, o_left_exp_wr_data,
                o_left_exp_wr_en, o_right_exp_wr_addr, o_right_exp_wr_data, o_right_exp_wr_en,
                o_busy, o_done});
  endfunction

  initial begin
    for (int t = 0; t < 2; t++)
      for (int n = 0; n < 16; n++)
        for (int b = 0; b < 32; b++)
          packed_mem[t][n][8*b +: 8] = (t == 0) ? 8'(n * 32 + b)
                                     : (n == 0) ? 8'(b) : 8'((n * 32 + b) ^ 8'h5A);

    // Reset, with a start pulse that coincides with the last reset cycle.
    tick(); tick();
    check("reset_outputs", all_outs(), 64'd0);
    i_start = 1'b1;
    tick();
    i_reset = 1'b0; i_start = 1'b0;
    tick();
    check("start_under_reset_busy", 64'(o_busy), 64'd0);
    tick();
    check("start_under_reset_outs", all_outs(), 64'd0);

    // Left job, all lines available.
    i_packed_lines_avail = 5'd16;
    begin_job(0, 1'b0, 16);
    wait_done_main(1'b0, 700);
    check("t1_done_cycle", 64'(done_cyc), 64'd529);
    check("t1_writes", 64'(wr_cnt[0]), 64'd512);
    check("t1_first_write", 64'(first_wr[0]), 64'd2);
    check("t1_last_write", 64'(last_wr[0]), 64'd528);
    check("t1_right_writes", 64'(right_cnt[0]), 64'd0);

    // Right job; line 0 carries bytes 0x00..0x1F.
    begin_job(0, 1'b1, 16);
    wait_done_main(1'b1, 700);
    check("t2_right_writes", 64'(right_cnt[0]), 64'd512);
    check("t2_done_cycle", 64'(done_cyc), 64'd529);

    // Stall: nothing available for 10 cycles, then one line per 33 cycles.
    i_packed_lines_avail = 5'd0;
    begin_job(0, 1'b0, 16);
    ramp = 1'b1;
    wait_done_main(1'b0, 800);
    ramp = 1'b0;
    check("t3_first_write", 64'(first_wr[0]), 64'd12);
    check("t3_last_write", 64'(last_wr[0]), 64'd538);
    check("t3_done_cycle", 64'(done_cyc), 64'd539);
    check("t3_writes", 64'(wr_cnt[0]), 64'd512);

    // Line 3 is rewritten mid-EMIT; the captured copy must still be emitted.
    i_packed_lines_avail = 5'd16;
    corrupt_cyc = 110;
    begin_job(0, 1'b0, 16);
    wait_done_main(1'b0, 700);
    corrupt_cyc = -1;
    check("t4_done_cycle", 64'(done_cyc), 64'd529);

    // Reset in cycle 200, then a complete right job.
    begin_job(0, 1'b0, 16);
    while (cyc < 200) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check("t5_outs_after_reset", all_outs(), 64'd0);
    check("t5_writes_before_reset", 64'(wr_cnt[0]), 64'd193);
    sb0.delete();
    tick();
    check("t5_idle_after_reset", all_outs(), 64'd0);
    begin_job(0, 1'b1, 16);
    wait_done_main(1'b1, 700);
    check("t5_restart_writes", 64'(wr_cnt[0]), 64'd512);
    check("t5_restart_done", 64'(done_cyc), 64'd529);

    // NUM_EXP=128 instance: start pulses while busy and while done are ignored.
    begin_job(1, 1'b0, 4);
    while (s_done_cyc < 0 && cyc < 400) begin
      tick();
      s_start = (cyc == 50) || s_done;
    end
    check("t6_done_seen", 64'(s_done_cyc), 64'd133);
    tick();
    s_start = 1'b0;
    check("t6_busy_after_done", 64'(s_busy), 64'd0);
    tick();
    check("t6_no_restart", 64'(s_busy), 64'd0);
    check("t6_writes", 64'(wr_cnt[1]), 64'd128);
    check("t6_last_write", 64'(last_wr[1]), 64'd132);
    check("t6_sb_drained", 64'(sb1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
